// File: rtl/user_arb_pkg.sv
// Shared types and width helpers for the user-domain OBI arbiter.
// Holds the default OBI bundle layout used by the arbiter ports.
package user_arb_pkg;

    localparam int unsigned ObiAddrW = 32;
    localparam int unsigned ObiDataW = 32;
    localparam int unsigned ObiIdW   = 1;

    typedef struct packed {
        logic [ObiAddrW-1:0]   addr;
        logic                  we;
        logic [ObiDataW/8-1:0] be;
        logic [ObiDataW-1:0]   wdata;
        logic [ObiIdW-1:0]     aid;
    } arb_obi_a_chan_t;

    typedef struct packed {
        logic            req;
        arb_obi_a_chan_t a;
    } arb_obi_req_t;

    typedef struct packed {
        logic [ObiDataW-1:0] rdata;
        logic [ObiIdW-1:0]   rid;
        logic                err;
    } arb_obi_r_chan_t;

    typedef struct packed {
        logic            gnt;
        logic            rvalid;
        arb_obi_r_chan_t r;
    } arb_obi_rsp_t;

    // Index width for n items, never below one bit.
    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of an occupancy counter that must reach d.
    function automatic int unsigned cnt_width(int unsigned d);
        return $clog2(d + 1);
    endfunction

endpackage

// File: rtl/user_arb_owner_fifo.sv
// In-order FIFO recording which upstream port owns each accepted
// transaction; push and pop may happen in the same cycle.
module user_arb_owner_fifo
    import user_arb_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = idx_width(Depth);
    localparam int unsigned CntW = cnt_width(Depth);

    typedef logic [PtrW-1:0] ptr_t;

    logic [Width-1:0] mem_q [Depth];
    ptr_t             wr_q, wr_d;
    ptr_t             rd_q, rd_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic ptr_t ptr_inc(ptr_t p);
        return (p == ptr_t'(Depth - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_q];

    // Pointer and occupancy next-state; push+pop leaves the count as is.
    always_comb begin
        wr_d  = do_push ? ptr_inc(wr_q) : wr_q;
        rd_d  = do_pop ? ptr_inc(rd_q) : rd_q;
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    // Storage and pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            if (do_push) begin
                mem_q[wr_q] <= data_i;
            end
        end
    end

endmodule

// File: rtl/user_obi_rr_arbiter.sv
// Round-robin OBI arbiter sharing one subordinate between NumReq
// managers; responses are routed by an owner FIFO, not by aid.
module user_obi_rr_arbiter
    import user_arb_pkg::*;
#(
    parameter type         obi_req_t = arb_obi_req_t,
    parameter type         obi_rsp_t = arb_obi_rsp_t,
    parameter int unsigned NumReq    = 2,
    parameter int unsigned MaxTrans  = 2
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  obi_req_t sbr_req_i [NumReq],
    output obi_rsp_t sbr_rsp_o [NumReq],
    output obi_req_t mgr_req_o,
    input  obi_rsp_t mgr_rsp_i,
    output logic     spurious_o
);

    localparam int unsigned IdxW = idx_width(NumReq);

    typedef logic [IdxW-1:0] idx_t;

    idx_t rr_q, rr_d;
    idx_t lock_idx_q, lock_idx_d;
    logic lock_q, lock_d;
    logic spurious_q, spurious_d;
    idx_t sel, head;
    logic sel_vld, fwd, hs, stall, pop, full, empty;

    // Locked port wins; otherwise first requester from rr_q upward.
    always_comb begin
        int unsigned j;
        j       = 0;
        sel     = lock_idx_q;
        sel_vld = lock_q;
        if (!lock_q) begin
            sel = '0;
            for (int unsigned k = 0; k < NumReq; k++) begin
                j = 32'(rr_q) + k;
                if (j >= NumReq) begin
                    j = j - NumReq;
                end
                if (!sel_vld && sbr_req_i[idx_t'(j)].req) begin
                    sel_vld = 1'b1;
                    sel     = idx_t'(j);
                end
            end
        end
    end

    // A-channel forward; nothing goes out while the owner FIFO is full.
    always_comb begin
        fwd       = rst_ni & sel_vld & ~full;
        mgr_req_o = '0;
        if (fwd) begin
            mgr_req_o = sbr_req_i[sel];
        end
        hs    = mgr_req_o.req & mgr_rsp_i.gnt;
        stall = mgr_req_o.req & ~mgr_rsp_i.gnt;
        pop   = rst_ni & mgr_rsp_i.rvalid & ~empty;
    end

    // Per-port grant and response routing to the FIFO head owner.
    always_comb begin
        for (int unsigned i = 0; i < NumReq; i++) begin
            sbr_rsp_o[i] = '0;
            if (fwd && sel == idx_t'(i)) begin
                sbr_rsp_o[i].gnt = hs;
            end
            if (pop && head == idx_t'(i)) begin
                sbr_rsp_o[i].rvalid = 1'b1;
                sbr_rsp_o[i].r      = mgr_rsp_i.r;
            end
        end
    end

    // Pointer advance on grant; lock onto a port waiting for its grant.
    always_comb begin
        rr_d       = rr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (hs) begin
            rr_d   = (sel == idx_t'(NumReq - 1)) ? '0 : sel + idx_t'(1);
            lock_d = 1'b0;
        end else if (stall) begin
            lock_d     = 1'b1;
            lock_idx_d = sel;
        end
        spurious_d = spurious_q | (rst_ni & mgr_rsp_i.rvalid & empty);
    end

    // Arbitration state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            spurious_q <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            spurious_q <= spurious_d;
        end
    end

    assign spurious_o = spurious_q;

    user_arb_owner_fifo #(
        .Depth (MaxTrans),
        .Width (IdxW)
    ) u_owner_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (hs),
        .data_i  (sel),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

endmodule
